// File: rtl/riscv_mem_pkg.sv
// Shared types and default sizes for the data-memory
// controller and its store buffer.
package riscv_mem_pkg;

   localparam int DATA_W_DEF   = 32;
   localparam int ADDR_W_DEF   = 9;
   localparam int SB_DEPTH_DEF = 4;

   typedef enum logic [1:0] {
      IDLE,
      DRAIN,
      READ,
      RESP
   } mem_state_e;

endpackage

// File: rtl/store_buf.sv
// FIFO store buffer with a youngest-match lookup port
// so loads can forward buffered store data.
module store_buf
   import riscv_mem_pkg::*;
#(
   parameter int DATA_W   = DATA_W_DEF,
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int SB_DEPTH = SB_DEPTH_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              push,
   input  logic [ADDR_W-1:0] push_addr,
   input  logic [DATA_W-1:0] push_data,
   input  logic              pop,
   input  logic [ADDR_W-1:0] look_addr,
   output logic              hit,
   output logic [DATA_W-1:0] hit_data,
   output logic [ADDR_W-1:0] head_addr,
   output logic [DATA_W-1:0] head_data,
   output logic              empty,
   output logic              full
);

   localparam int PTR_W = $clog2(SB_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [ADDR_W-1:0] addr_q [SB_DEPTH];
   logic [DATA_W-1:0] data_q [SB_DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [CNT_W-1:0]  count;
   logic              do_pop;
   logic [PTR_W-1:0]  idx;

   assign empty     = (count == '0);
   assign full      = (count == CNT_W'(SB_DEPTH));
   assign do_pop    = pop & ~empty;
   assign head_addr = addr_q[rd_ptr];
   assign head_data = data_q[rd_ptr];

   always_ff @(posedge clk) begin
      if (push) begin
         addr_q[wr_ptr] <= push_addr;
         data_q[wr_ptr] <= push_data;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)
            rd_ptr <= rd_ptr + 1'b1;
         unique case ({push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Walk oldest to youngest so the last match wins.
   always_comb begin
      hit      = 1'b0;
      hit_data = '0;
      idx      = '0;
      for (int i = 0; i < SB_DEPTH; i++) begin
         idx = rd_ptr + PTR_W'(i);
         if ((CNT_W'(i) < count) && (addr_q[idx] == look_addr)) begin
            hit      = 1'b1;
            hit_data = data_q[idx];
         end
      end
   end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: buffered stores, forwarding
// loads, and a single-port backing-memory sequencer.
module dmem_ctrl
   import riscv_mem_pkg::*;
#(
   parameter int DATA_W   = DATA_W_DEF,
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int SB_DEPTH = SB_DEPTH_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              core_wr,
   input  logic              core_rd,
   input  logic [ADDR_W-1:0] core_addr,
   input  logic [DATA_W-1:0] core_wr_data,
   output logic [DATA_W-1:0] core_rd_data,
   output logic              core_stall,
   output logic              sb_empty,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata
);

   mem_state_e        state_q;
   mem_state_e        state_d;
   logic              sb_hit;
   logic              sb_full;
   logic [DATA_W-1:0] sb_hit_data;
   logic [ADDR_W-1:0] head_addr;
   logic [DATA_W-1:0] head_data;
   logic [DATA_W-1:0] rd_q;
   logic              push;
   logic              pop;
   logic              ld_req;
   logic              ld_miss;

   // A simultaneous store wins; the load is not seen.
   assign ld_req  = core_rd & ~core_wr;
   assign ld_miss = ld_req & ~sb_hit;
   assign push    = core_wr & ~sb_full;
   assign pop     = (state_q == DRAIN) & mem_ack;

   store_buf #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .SB_DEPTH (SB_DEPTH)
   ) u_sb (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .push_addr (core_addr),
      .push_data (core_wr_data),
      .pop       (pop),
      .look_addr (core_addr),
      .hit       (sb_hit),
      .hit_data  (sb_hit_data),
      .head_addr (head_addr),
      .head_data (head_data),
      .empty     (sb_empty),
      .full      (sb_full)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (ld_miss)
               state_d = READ;
            else if (!sb_empty)
               state_d = DRAIN;
         end
         DRAIN: if (mem_ack) state_d = IDLE;
         READ:  if (mem_ack) state_d = RESP;
         RESP:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      core_stall = (core_wr & sb_full)
                 | (ld_miss & (state_q != RESP));
      core_rd_data = '0;
      if (state_q == RESP)
         core_rd_data = rd_q;
      else if (ld_req && sb_hit)
         core_rd_data = sb_hit_data;
   end

   // Request fields are loaded on entry so they stay put until ack.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         rd_q      <= '0;
      end else begin
         if (state_q == IDLE && state_d == DRAIN) begin
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= head_addr;
            mem_wdata <= head_data;
         end else if (state_q == IDLE && state_d == READ) begin
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= core_addr;
         end else if ((state_q == DRAIN || state_q == READ) && mem_ack) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
         end
         if (state_q == READ && mem_ack)
            rd_q <= mem_rdata;
      end
   end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl with an ack-delay memory
// responder that logs every completed transaction.
module tb_dmem_ctrl;
   import riscv_mem_pkg::*;

   localparam int DW = 32;
   localparam int AW = 9;

   logic          clk = 1'b0;
   logic          reset;
   logic          core_wr;
   logic          core_rd;
   logic [AW-1:0] core_addr;
   logic [DW-1:0] core_wr_data;
   logic [DW-1:0] core_rd_data;
   logic          core_stall;
   logic          sb_empty;
   logic          mem_req;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic          mem_ack;
   logic [DW-1:0] mem_rdata;

   int n_chk  = 0;
   int n_fail = 0;

   bit            ack_en  = 1'b0;
   int            ack_lat = 1;
   logic [DW-1:0] rd_val  = '0;

   logic          ev_we   [$];
   logic [AW-1:0] ev_addr [$];
   logic [DW-1:0] ev_data [$];

   always #5 clk = ~clk;

   dmem_ctrl dut (
      .clk          (clk),
      .reset        (reset),
      .core_wr      (core_wr),
      .core_rd      (core_rd),
      .core_addr    (core_addr),
      .core_wr_data (core_wr_data),
      .core_rd_data (core_rd_data),
      .core_stall   (core_stall),
      .sb_empty     (sb_empty),
      .mem_req      (mem_req),
      .mem_we       (mem_we),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .mem_ack      (mem_ack),
      .mem_rdata    (mem_rdata)
   );

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Acks after mem_req has been seen for ack_lat cycles.
   initial begin : resp
      int cnt;
      cnt       = 0;
      mem_ack   = 1'b0;
      mem_rdata = '0;
      forever begin
         @(posedge clk);
         #1;
         mem_ack = 1'b0;
         if (!mem_req) begin
            cnt = 0;
         end else begin
            cnt++;
            if (ack_en && cnt >= ack_lat) begin
               mem_ack   = 1'b1;
               mem_rdata = mem_we ? '0 : rd_val;
               ev_we.push_back(mem_we);
               ev_addr.push_back(mem_addr);
               ev_data.push_back(mem_we ? mem_wdata : rd_val);
               cnt = 0;
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic wr, input logic rd,
                        input logic [AW-1:0] a,
                        input logic [DW-1:0] d);
      core_wr      = wr;
      core_rd      = rd;
      core_addr    = a;
      core_wr_data = d;
   endtask

   task automatic clr_log();
      ev_we.delete();
      ev_addr.delete();
      ev_data.delete();
   endtask

   task automatic wait_idle(input string tag, input int budget);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if (sb_empty && !mem_req) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
      chk({tag, "_idle"}, 32'(ok), 32'd1);
   endtask

   task automatic chk_ev(input string tag, input int i,
                         input logic we,
                         input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
      if (i < ev_we.size()) begin
         chk({tag, "_we"}, 32'(ev_we[i]), 32'(we));
         chk({tag, "_addr"}, 32'(ev_addr[i]), 32'(a));
         chk({tag, "_data"}, ev_data[i], d);
      end else begin
         chk({tag, "_missing"}, 32'(ev_we.size()), 32'(i + 1));
      end
   endtask

   initial begin
      bit got;
      reset = 1'b0;
      drive(1'b0, 1'b0, '0, '0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_empty", 32'(sb_empty), 32'd1);
      chk("rst_req", 32'(mem_req), 32'd0);
      chk("rst_we", 32'(mem_we), 32'd0);
      chk("rst_addr", 32'(mem_addr), 32'd0);
      chk("rst_wdata", mem_wdata, 32'd0);
      chk("rst_rdata", core_rd_data, 32'd0);
      chk("rst_stall", 32'(core_stall), 32'd0);
      tick();
      reset = 1'b1;

      // store then same-address load forwards
      ack_en  = 1'b1;
      ack_lat = 1;
      clr_log();
      drive(1'b1, 1'b0, 9'd5, 32'h11);
      @(negedge clk);
      chk("t1_st_stall", 32'(core_stall), 32'd0);
      tick();
      drive(1'b0, 1'b1, 9'd5, '0);
      @(negedge clk);
      chk("t1_hit_data", core_rd_data, 32'h11);
      chk("t1_hit_stall", 32'(core_stall), 32'd0);
      tick();
      drive(1'b0, 1'b0, '0, '0);
      wait_idle("t1", 20);
      chk("t1_nev", 32'(ev_we.size()), 32'd1);
      chk_ev("t1_ev0", 0, 1'b1, 9'd5, 32'h11);

      // two stores to one address, youngest forwarded
      clr_log();
      drive(1'b1, 1'b0, 9'd7, 32'hA);
      tick();
      drive(1'b1, 1'b0, 9'd7, 32'hB);
      tick();
      drive(1'b0, 1'b1, 9'd7, '0);
      @(negedge clk);
      chk("t2_hit_data", core_rd_data, 32'hB);
      chk("t2_hit_stall", 32'(core_stall), 32'd0);
      tick();
      drive(1'b0, 1'b0, '0, '0);
      wait_idle("t2", 20);
      chk("t2_nev", 32'(ev_we.size()), 32'd2);
      chk_ev("t2_ev0", 0, 1'b1, 9'd7, 32'hA);
      chk_ev("t2_ev1", 1, 1'b1, 9'd7, 32'hB);

      // fill with acks withheld, fifth store stalls
      clr_log();
      ack_en = 1'b0;
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 1'b0, 9'(16 + i), 32'(256 + i));
         @(negedge clk);
         chk("t3_fill_stall", 32'(core_stall), 32'd0);
         if (i > 0)
            chk("t3_fill_nonempty", 32'(sb_empty), 32'd0);
         tick();
      end
      drive(1'b1, 1'b0, 9'd20, 32'h104);
      for (int j = 0; j < 3; j++) begin
         @(negedge clk);
         chk("t3_full_stall", 32'(core_stall), 32'd1);
         chk("t3_full_nonempty", 32'(sb_empty), 32'd0);
         if (j == 2)
            ack_en = 1'b1;
         tick();
      end
      @(negedge clk);
      chk("t3_ack_cycle_stall", 32'(core_stall), 32'd1);
      chk("t3_ack_cycle_nonempty", 32'(sb_empty), 32'd0);
      tick();
      @(negedge clk);
      chk("t3_accept_stall", 32'(core_stall), 32'd0);
      chk("t3_accept_nonempty", 32'(sb_empty), 32'd0);
      tick();
      drive(1'b0, 1'b0, '0, '0);
      wait_idle("t3", 60);
      chk("t3_nev", 32'(ev_we.size()), 32'd5);
      for (int i = 0; i < 5; i++)
         chk_ev("t3_ev", i, 1'b1, 9'(16 + i), 32'(256 + i));

      // load miss with three-cycle memory latency
      clr_log();
      ack_lat = 3;
      rd_val  = 32'hDEAD;
      drive(1'b0, 1'b1, 9'd9, '0);
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         chk("t4_stall", 32'(core_stall), 32'd1);
         chk("t4_data", core_rd_data, 32'd0);
         if (c > 0) begin
            chk("t4_req", 32'(mem_req), 32'd1);
            chk("t4_we", 32'(mem_we), 32'd0);
            chk("t4_addr", 32'(mem_addr), 32'd9);
         end
         tick();
      end
      @(negedge clk);
      chk("t4_resp_stall", 32'(core_stall), 32'd0);
      chk("t4_resp_data", core_rd_data, 32'hDEAD);
      chk("t4_resp_req", 32'(mem_req), 32'd0);
      tick();
      drive(1'b0, 1'b0, '0, '0);
      @(negedge clk);
      chk("t4_after_data", core_rd_data, 32'd0);
      chk("t4_nev", 32'(ev_we.size()), 32'd1);
      chk_ev("t4_ev0", 0, 1'b0, 9'd9, 32'hDEAD);
      tick();

      // load miss while a drain waits for its ack
      clr_log();
      ack_en  = 1'b0;
      ack_lat = 1;
      rd_val  = 32'h1234;
      drive(1'b1, 1'b0, 9'h20, 32'h55);
      tick();
      drive(1'b0, 1'b0, '0, '0);
      tick();
      drive(1'b0, 1'b1, 9'h30, '0);
      @(negedge clk);
      chk("t5_stall", 32'(core_stall), 32'd1);
      chk("t5_drain_we", 32'(mem_we), 32'd1);
      chk("t5_drain_addr", 32'(mem_addr), 32'h20);
      ack_en = 1'b1;
      tick();
      got = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (!core_stall) begin
            got = 1'b1;
            break;
         end
         tick();
      end
      chk("t5_resp_seen", 32'(got), 32'd1);
      chk("t5_resp_data", core_rd_data, 32'h1234);
      tick();
      drive(1'b0, 1'b0, '0, '0);
      wait_idle("t5", 20);
      chk("t5_nev", 32'(ev_we.size()), 32'd2);
      chk_ev("t5_ev0", 0, 1'b1, 9'h20, 32'h55);
      chk_ev("t5_ev1", 1, 1'b0, 9'h30, 32'h1234);

      // reset mid-read drops request and buffered stores
      clr_log();
      ack_en = 1'b0;
      drive(1'b1, 1'b0, 9'h50, 32'h66);
      tick();
      drive(1'b0, 1'b1, 9'h40, '0);
      @(negedge clk);
      chk("t6_miss_stall", 32'(core_stall), 32'd1);
      tick();
      @(negedge clk);
      chk("t6_req", 32'(mem_req), 32'd1);
      chk("t6_we", 32'(mem_we), 32'd0);
      chk("t6_addr", 32'(mem_addr), 32'h40);
      chk("t6_nonempty", 32'(sb_empty), 32'd0);
      #2;
      reset = 1'b0;
      #1;
      chk("t6_rst_req", 32'(mem_req), 32'd0);
      chk("t6_rst_empty", 32'(sb_empty), 32'd1);
      chk("t6_rst_addr", 32'(mem_addr), 32'd0);
      drive(1'b0, 1'b0, '0, '0);
      tick();
      reset  = 1'b1;
      ack_en = 1'b1;
      @(negedge clk);
      chk("t6_state", 32'(dut.state_q), 32'(IDLE));
      chk("t6_post_req", 32'(mem_req), 32'd0);
      repeat (4) tick();
      chk("t6_nev", 32'(ev_we.size()), 32'd0);
      chk("t6_post_empty", 32'(sb_empty), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/dmem_ctrl.md
DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 Parameters SHALL be: DATA_W, default 32, data width; ADDR_W, default 9, word address width; SB_DEPTH, default 4, store-buffer entries (power of 2, >=2).
REQ-002 Ports SHALL be:
- clk  in  1  clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- core_wr  in  1  store request from core.
- core_rd  in  1  load request from core.
- core_addr  in  ADDR_W  load/store word address.
- core_wr_data  in  DATA_W  store data.
- core_rd_data  out  DATA_W  load data.
- core_stall  out  1  core must hold request and inputs stable.
- sb_empty  out  1  store buffer holds no entries.
- mem_req  out  1  backing-memory request.
- mem_we  out  1  1 = write, 0 = read.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_ack  in  1  one-cycle completion pulse.
- mem_rdata  in  DATA_W  read data, valid in the mem_ack cycle.

Function
REQ-003 Stores SHALL enter a SB_DEPTH-entry FIFO store buffer in one cycle when count < SB_DEPTH; core_stall SHALL be 1 while core_wr=1 and count == SB_DEPTH, even if a pop occurs that cycle.
REQ-004 Stores to an address already buffered SHALL append a new entry; no merging.
REQ-005 A load SHALL compare core_addr against all valid entries; on a hit, core_rd_data SHALL combinationally equal the youngest matching entry's data, with core_stall=0 (zero latency).
REQ-006 On a load miss, core_stall SHALL be 1 until the RESP cycle.
REQ-007 The FSM SHALL have states IDLE, DRAIN, READ, RESP.
REQ-008 IDLE -> READ on a load miss (priority); else IDLE -> DRAIN if count > 0; else stay in IDLE.
REQ-009 DRAIN SHALL drive mem_req=1, mem_we=1, and the head entry's address and data, all held stable. On mem_ack it SHALL pop the head and go to IDLE.
REQ-010 READ SHALL drive mem_req=1, mem_we=0, mem_addr=core_addr. On mem_ack it SHALL latch mem_rdata and go to RESP.
REQ-011 RESP SHALL drive core_rd_data from the latched value with core_stall=0 for exactly one cycle, then go to IDLE.
REQ-012 A load miss arriving during DRAIN SHALL wait for that drain's ack, then re-evaluate the hit in IDLE.
REQ-013 Push and pop in the same cycle SHALL leave count unchanged; FIFO pointers SHALL wrap modulo SB_DEPTH.
REQ-014 core_wr and core_rd both high SHALL be handled as the store only; the load is ignored that cycle.
REQ-015 core_rd_data SHALL be 0 when neither a hit nor RESP applies.
REQ-016 mem_req SHALL be 0 in IDLE and RESP; sb_empty SHALL equal (count == 0).
REQ-017 mem_ack received in IDLE or RESP SHALL be ignored.

Reset
REQ-018 reset=0 SHALL immediately set: state IDLE, count 0, pointers 0, mem_req 0, mem_we 0, mem_addr 0, mem_wdata 0, and the latched read data 0.
REQ-019 Reset during DRAIN or READ SHALL abandon the transaction (mem_req drops asynchronously) and discard all buffered stores.

Structure
REQ-020 Package riscv_mem_pkg SHALL hold the FSM state enum (IDLE, DRAIN, READ, RESP) and the default width and depth constants.
REQ-021 The FIFO storage and address-match/youngest-hit logic SHALL be sub-module store_buf; dmem_ctrl SHALL hold the FSM and the memory-side registers.

Verification
REQ-022 The bench SHALL cover:
- Store 0x11 to addr 5, then load addr 5 next cycle -> core_rd_data=0x11 that cycle, core_stall=0, no mem read issued.
- Stores 0xA then 0xB to addr 7, then load addr 7 -> 0xB returned; two drains to addr 7 in order 0xA, 0xB.
- Fill 4 stores with mem_ack withheld; 5th store -> core_stall=1 until the cycle after the first mem_ack, then accepted; sb_empty=0 throughout.
- Load miss addr 9, memory acks after 3 cycles with 0xDEAD -> core_stall=1 for 4 cycles, then RESP with core_rd_data=0xDEAD and core_stall=0.
- Load miss issued while a drain is pending ack -> write completes first, then mem read to the load address.
- Assert reset=0 during READ -> mem_req=0 in the same cycle, sb_empty=1, state IDLE after release.
